// File: rtl/axi4_rr_arbiter.sv
// Round-robin arbiter granting whole AXI4 transactions on a shared slave port.
// Optional watchdog release is built when AXI4_ARB_TIMEOUT_EN is defined.
module axi4_rr_arbiter #(
  parameter int NUM_MASTERS    = 4,
  parameter int IDX_W          = $clog2(NUM_MASTERS),
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [NUM_MASTERS-1:0] req_is_write,
  output logic [NUM_MASTERS-1:0] gnt,
  output logic [IDX_W-1:0]       gnt_idx,
  output logic                   gnt_valid,
  input  logic                   s_awvalid,
  input  logic                   s_awready,
  input  logic                   s_wvalid,
  input  logic                   s_wready,
  input  logic                   s_wlast,
  input  logic                   s_bvalid,
  input  logic                   s_bready,
  input  logic                   s_arvalid,
  input  logic                   s_arready,
  input  logic                   s_rvalid,
  input  logic                   s_rready,
  input  logic                   s_rlast,
  output logic                   timeout_err
);

  if (NUM_MASTERS < 2 || NUM_MASTERS > 16 || TIMEOUT_CYCLES < 2) begin : g_cfg_check
    $error("axi4_rr_arbiter: unsupported NUM_MASTERS or TIMEOUT_CYCLES");
  end

  typedef enum logic [1:0] {IDLE, WR_ADDR_DATA, WR_RESP, RD_DATA} state_t;

  localparam logic [NUM_MASTERS-1:0] ONE = NUM_MASTERS'(1);

  state_t                 state_q, state_d;
  logic [NUM_MASTERS-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0]       gnt_idx_q, gnt_idx_d;
  logic [IDX_W-1:0]       last_idx_q, last_idx_d;
  logic                   aw_done_q, aw_done_d;
  logic                   w_done_q, w_done_d;
  logic                   ar_done_q, ar_done_d;
  logic                   found;
  logic [IDX_W-1:0]       winner;
  logic                   aw_hs, w_hs, b_hs, ar_hs, rlast_hs;

  // Descending scan so the candidate closest to last_idx+1 is written last and wins.
  function automatic logic [IDX_W:0] pick_next(input logic [NUM_MASTERS-1:0] r,
                                               input logic [IDX_W-1:0]       last);
    logic [IDX_W-1:0]       cand;
    logic [NUM_MASTERS-1:0] sh;
    logic [IDX_W:0]         res;
    res = '0;
    for (int i = NUM_MASTERS; i >= 1; i--) begin
      cand = IDX_W'((int'(last) + i) % NUM_MASTERS);
      sh   = r >> cand;
      if (sh[0]) res = {1'b1, cand};
    end
    return res;
  endfunction

  assign aw_hs    = s_awvalid & s_awready;
  assign w_hs     = s_wvalid & s_wready & s_wlast;
  assign b_hs     = s_bvalid & s_bready;
  assign ar_hs    = s_arvalid & s_arready;
  assign rlast_hs = s_rvalid & s_rready & s_rlast;

  assign {found, winner} = pick_next(req, last_idx_q);

`ifdef AXI4_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tmo_q, tmo_d;
  logic             phase_hit;

  // Any handshake that advances the current phase counts as progress.
  assign phase_hit = ((state_q == WR_ADDR_DATA) && (aw_hs || w_hs)) ||
                     ((state_q == WR_RESP) && b_hs) ||
                     ((state_q == RD_DATA) && (ar_hs || (rlast_hs && ar_done_q)));
`endif

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    gnt_idx_d  = gnt_idx_q;
    last_idx_d = last_idx_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    ar_done_d  = ar_done_q;
    case (state_q)
      IDLE: begin
        gnt_d     = '0;
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        ar_done_d = 1'b0;
        if (found) begin
          gnt_d      = ONE << winner;
          gnt_idx_d  = winner;
          last_idx_d = winner;
          state_d    = req_is_write[winner] ? WR_ADDR_DATA : RD_DATA;
        end
      end
      WR_ADDR_DATA: begin
        aw_done_d = aw_done_q | aw_hs;
        w_done_d  = w_done_q | w_hs;
        if (aw_done_d && w_done_d) state_d = WR_RESP;
      end
      WR_RESP: begin
        if (b_hs) begin
          state_d = IDLE;
          gnt_d   = '0;
        end
      end
      RD_DATA: begin
        ar_done_d = ar_done_q | ar_hs;
        // R data cannot legally precede the AR handshake, so such a last beat is dropped.
        if (rlast_hs && ar_done_q) begin
          state_d = IDLE;
          gnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
`ifdef AXI4_ARB_TIMEOUT_EN
    tmo_d = 1'b0;
    cnt_d = cnt_q + 1'b1;
    if (state_q == IDLE || phase_hit) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
      state_d = IDLE;
      gnt_d   = '0;
      tmo_d   = 1'b1;
      cnt_d   = '0;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      gnt_idx_q  <= '0;
      last_idx_q <= IDX_W'(NUM_MASTERS - 1);
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      ar_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      gnt_idx_q  <= gnt_idx_d;
      last_idx_q <= last_idx_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
      ar_done_q  <= ar_done_d;
    end
  end

`ifdef AXI4_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      tmo_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tmo_q <= tmo_d;
    end
  end

  assign timeout_err = tmo_q;
`else
  assign timeout_err = 1'b0;
`endif

  assign gnt       = gnt_q;
  assign gnt_idx   = gnt_idx_q;
  assign gnt_valid = |gnt_q;

endmodule

// File: tb/tb_axi4_rr_arbiter.sv
// Scoreboard bench for axi4_rr_arbiter: the driver predicts grants/releases, a negedge monitor checks them.
module tb_axi4_rr_arbiter;
  localparam int N   = 4;
  localparam int TMO = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] req, req_is_write, gnt;
  logic [1:0]   gnt_idx;
  logic         gnt_valid, timeout_err;
  logic         s_awvalid, s_awready, s_wvalid, s_wready, s_wlast, s_bvalid, s_bready;
  logic         s_arvalid, s_arready, s_rvalid, s_rready, s_rlast;

  always #5 clk = ~clk;

  axi4_rr_arbiter #(.NUM_MASTERS(N), .IDX_W(2), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .req(req), .req_is_write(req_is_write),
    .gnt(gnt), .gnt_idx(gnt_idx), .gnt_valid(gnt_valid),
    .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wlast(s_wlast),
    .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rlast(s_rlast),
    .timeout_err(timeout_err)
  );

  typedef struct {int idx; int cyc;} gexp_t;
  gexp_t grant_q[$];
  int    rel_q[$];
  gexp_t mon_e;

  int   cyc = 0;
  int   checks = 0, passed = 0;
  int   model_last = N - 1;
  int   idle_from = 0;
  int   hold_idx = 0;
  int   tmo_cyc = -1;
  bit   mon_en = 1'b0;
  logic prev_v = 1'b0;
  logic [N-1:0] prev_gnt = '0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, int act, int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
  endfunction

  // Reference rule: first requester found scanning upward from last+1 with wrap.
  function automatic int rr_pick(logic [N-1:0] r, int last);
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (last + k) % N;
      if (((r >> c) & 4'b0001) != 4'b0000) return c;
    end
    return -1;
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      check("gnt_valid_or", int'(gnt_valid), int'(gnt != '0));
      check("onehot", int'($countones(gnt) <= 1), 1);
      check("timeout_err", int'(timeout_err), int'(cyc == tmo_cyc));
      if (gnt_valid && !prev_v) begin
        if (grant_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_grant at cycle %0d: got idx %0d, expected none", cyc, gnt_idx);
        end else begin
          mon_e = grant_q.pop_front();
          check("grant_idx", int'(gnt_idx), mon_e.idx);
          check("grant_vec", int'(gnt), 1 << mon_e.idx);
          check("grant_cycle", cyc, mon_e.cyc);
          hold_idx = mon_e.idx;
        end
      end else if (gnt_valid && prev_v) begin
        check("grant_held", int'(gnt), int'(prev_gnt));
      end else if (!gnt_valid && prev_v) begin
        if (rel_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_release at cycle %0d: got release, expected none", cyc);
        end else begin
          check("release_cycle", cyc, rel_q.pop_front());
        end
      end
      if (!gnt_valid) check("idle_idx_hold", int'(gnt_idx), hold_idx);
      prev_v   = gnt_valid;
      prev_gnt = gnt;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_hs();
    s_awvalid = 0; s_awready = 0; s_wvalid = 0; s_wready = 0; s_wlast = 0;
    s_bvalid = 0; s_bready = 0; s_arvalid = 0; s_arready = 0;
    s_rvalid = 0; s_rready = 0; s_rlast = 0;
  endtask

  task automatic issue(input logic [N-1:0] r, input logic [N-1:0] w, output int win, output int g);
    gexp_t e;
    req = r;
    req_is_write = w;
    win = rr_pick(r, model_last);
    g = (cyc + 1 > idle_from) ? cyc + 1 : idle_from;
    e.idx = win;
    e.cyc = g;
    grant_q.push_back(e);
    model_last = win;
    while (cyc < g) step();
  endtask

  task automatic finish_at(input int c);
    rel_q.push_back(c + 1);
    idle_from = c + 2;
  endtask

  task automatic do_write(input int da, input int dw, input int db, input bit stray);
    int n;
    n = (da > dw) ? da : dw;
    for (int t = 0; t <= n; t++) begin
      s_awvalid = (t == da) || (t < da && ($urandom % 2 == 1));
      s_awready = (t == da);
      s_wvalid  = (t <= dw);
      s_wready  = (t == dw) || (t < dw && ($urandom % 2 == 1));
      s_wlast   = (t == dw);
      s_bvalid  = stray; s_bready = stray;
      s_rvalid  = stray; s_rready = stray; s_rlast = stray;
      step();
    end
    clear_hs();
    for (int t = 1; t < db; t++) begin
      s_bvalid = ($urandom % 2 == 1);
      step();
    end
    s_bvalid = 1; s_bready = 1;
    finish_at(cyc);
    step();
    clear_hs();
  endtask

  task automatic do_read(input int da, input int dr, input bit stray);
    for (int t = 0; t <= da; t++) begin
      s_arvalid = (t == da) || (t < da && ($urandom % 2 == 1));
      s_arready = (t == da);
      s_rvalid  = stray && (t < da); s_rready = stray && (t < da); s_rlast = stray && (t < da);
      s_awvalid = stray; s_awready = stray; s_bvalid = stray; s_bready = stray;
      step();
    end
    clear_hs();
    for (int t = 0; t < dr; t++) begin
      s_rvalid = 1; s_rready = ($urandom % 2 == 1); s_rlast = 0;
      step();
    end
    s_rvalid = 1; s_rready = 1; s_rlast = 1;
    finish_at(cyc);
    step();
    clear_hs();
  endtask

  // mode: 0 keep req, 1 scramble req while granted, 2 drop the winner's req bit
  task automatic txn(input logic [N-1:0] r, input logic [N-1:0] w, input int da, input int dw,
                     input int db, input bit stray, input int mode);
    int win, g;
    issue(r, w, win, g);
    if (mode == 1) req = 4'($urandom);
    if (mode == 2) req = req & ~(4'b0001 << win);
    if (((w >> win) & 4'b0001) != 4'b0000) do_write(da, dw, db, stray);
    else do_read(da, db, stray);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int win, g;
    logic [N-1:0] r;
    reset = 0; req = '0; req_is_write = '0;
    clear_hs();
    repeat (3) step();
    check("rst_gnt", int'(gnt), 0);
    check("rst_gnt_idx", int'(gnt_idx), 0);
    check("rst_gnt_valid", int'(gnt_valid), 0);
    check("rst_timeout_err", int'(timeout_err), 0);
    mon_en = 1'b1;
    reset = 1;
    step();

    // Single write: AW and W-last together, B three cycles later.
    txn(4'b0001, 4'b0001, 0, 0, 3, 1'b0, 0);
    // All masters requesting reads: rotation with a one-cycle gap.
    repeat (5) txn(4'b1111, 4'b0000, 0, 0, 0, 1'b0, 0);
    // W-last five cycles before AW, with stray B/R traffic that must be ignored.
    txn(4'b0010, 4'b0010, 5, 0, 2, 1'b1, 0);
    // Master 2 drops req mid-read; then 1001 must pick master 3.
    txn(4'b0100, 4'b0000, 2, 0, 3, 1'b1, 2);
    txn(4'b1001, 4'b0000, 1, 0, 1, 1'b0, 0);

    // Asynchronous reset while in WR_RESP.
    issue(4'b0100, 4'b0100, win, g);
    req = '0;
    s_awvalid = 1; s_awready = 1; s_wvalid = 1; s_wready = 1; s_wlast = 1;
    step();
    clear_hs();
    step();
    reset = 0;
    rel_q.push_back(cyc);
    hold_idx = 0;
    model_last = N - 1;
    idle_from = 0;
    #1;
    check("async_rst_gnt", int'(gnt), 0);
    check("async_rst_gnt_valid", int'(gnt_valid), 0);
    check("async_rst_gnt_idx", int'(gnt_idx), 0);
    repeat (2) step();
    reset = 1;
    txn(4'b0110, 4'b0000, 0, 0, 1, 1'b0, 0);

    // Randomized traffic.
    repeat (40) begin
      if ($urandom % 3 == 0) begin
        req = '0;
        repeat ($urandom_range(1, 3)) step();
      end
      r = 4'($urandom_range(1, 15));
      txn(r, 4'($urandom), $urandom % 4, $urandom % 4, $urandom_range(1, 3),
          1'($urandom % 2), $urandom % 2);
    end

`ifdef AXI4_ARB_TIMEOUT_EN
    issue(4'b0001, 4'b0001, win, g);
    req = '0;
    tmo_cyc = g + TMO;
    rel_q.push_back(g + TMO);
    idle_from = g + TMO + 1;
    while (cyc < g + TMO + 3) step();
`else
    issue(4'b0001, 4'b0001, win, g);
    req = '0;
    repeat (1000) step();
    check("held_1000_gnt", int'(gnt), 1);
    check("held_1000_valid", int'(gnt_valid), 1);
    do_write(0, 0, 1, 1'b0);
`endif

    req = '0;
    repeat (3) step();
    check("grants_pending", grant_q.size(), 0);
    check("releases_pending", rel_q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
